// File: rtl/access_sample_timer.sv
// Randomised access sampler: counts accesses down a pseudo-random interval and captures the selected address.
// Latency: a firing access is visible on sample_valid/sample_addr right after its edge; lfsr_enable is combinational.
// Backpressure: single-entry output buffer; fires into a full, unaccepted buffer are dropped and counted.
module access_sample_timer #(
  parameter int OFFSET = 64,
  parameter int AW     = 32,
  parameter int DW     = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          access_valid,
  input  logic [AW-1:0] access_addr,
  input  logic [6:0]    lfsr_in,
  output logic          lfsr_enable,
  output logic          sample_valid,
  output logic [AW-1:0] sample_addr,
  input  logic          sample_ready,
  output logic [DW-1:0] drop_count,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] drop_q, drop_d;

  logic [7:0]    ivl_raw;
  logic [7:0]    ivl;
  logic          count_en;
  logic          fire;

  // Interval from the current LFSR value; OFFSET <= 128 keeps the sum inside 8 bits, zero is clamped to 1.
  assign ivl_raw  = {1'b0, lfsr_in} + 8'(OFFSET);
  assign ivl      = (ivl_raw == 8'd0) ? 8'd1 : ivl_raw;

  // Enabled accesses count in RUN and in the PAUSE cycle that resumes; INIT never counts.
  assign count_en = (state_q != S_INIT) && enable && access_valid;
  assign fire     = count_en && (cnt_q == 8'd1);

  // State register plus all datapath registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= 8'd0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
    end
  end

  // Next state: INIT lasts one cycle, then enable alone selects RUN or PAUSE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_RUN;
      S_RUN:   state_d = enable ? S_RUN : S_PAUSE;
      S_PAUSE: state_d = enable ? S_RUN : S_PAUSE;
      default: state_d = S_INIT;
    endcase
  end

  // Outputs: LFSR advance on load/reload cycles only (held low during reset), busy reflects RUN.
  always_comb begin
    lfsr_enable = 1'b0;
    busy        = 1'b0;
    if (!reset) begin
      lfsr_enable = (state_q == S_INIT) || fire;
    end
    busy = (state_q == S_RUN);
  end

  // Interval counter: load in INIT, reload on fire, otherwise decrement per counted access.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = ivl;
    end else if (count_en) begin
      cnt_d = fire ? ivl : (cnt_q - 8'd1);
    end
  end

  // Output buffer: a fire loads when empty or being drained this cycle, else the sample is dropped.
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    drop_d = drop_q;
    if (fire) begin
      if (!vld_q || sample_ready) begin
        vld_d  = 1'b1;
        addr_d = access_addr;
      end else if (drop_q != {DW{1'b1}}) begin
        drop_d = drop_q + DW'(1);
      end
    end else if (vld_q && sample_ready) begin
      vld_d = 1'b0;
    end
  end

  assign sample_valid = vld_q;
  assign sample_addr  = addr_q;
  assign drop_count   = drop_q;

endmodule
